// File: rtl/game_sequencer.sv
// -----------------------------------------------------------------------------
// game_sequencer
//   Top-level game-flow controller for breakout. It walks through the attract,
//   block reload, serve, play, life-lost, level-clear and game-over phases. It
//   owns the lives and level counters, and the score counter when that counter
//   is built in. Frame-paced waits are counted on frame_pulse.
//
//   Optional feature macro: GAME_SEQ_SCORE_EN
//     defined     -> saturating score counter, incremented by block_hit in PLAY
//     not defined -> no score register; score is tied to zero
// -----------------------------------------------------------------------------
module game_sequencer #(
    parameter int START_LIVES  = 3,
    parameter int LOST_FRAMES  = 90,
    parameter int CLEAR_FRAMES = 120,
    parameter int SCORE_W      = 10
) (
    input  logic               clk,
    input  logic               nRst,
    input  logic               frame_pulse,
    input  logic               btn_select,
    input  logic               ball_lost,
    input  logic               block_hit,
    input  logic               blocks_empty,
    input  logic               reload_done,
    output logic               blocks_reload,
    output logic               ball_hold,
    output logic               ball_launch,
    output logic               play_active,
    output logic               game_over,
    output logic [2:0]         lives,
    output logic [3:0]         level,
    output logic [SCORE_W-1:0] score
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RELOAD  = 3'd1,
        S_SERVE   = 3'd2,
        S_PLAY    = 3'd3,
        S_LOST    = 3'd4,
        S_CLEARED = 3'd5,
        S_OVER    = 3'd6
    } state_e;

    localparam logic [2:0] LIVES_INIT = 3'(START_LIVES);
    localparam logic [7:0] LOST_LIM   = 8'(LOST_FRAMES);
    localparam logic [7:0] CLEAR_LIM  = 8'(CLEAR_FRAMES);

    // Button synchroniser and edge detector
    logic sel_meta_q, sel_sync_q, sel_prev_q;
    logic press_s;

    // Architectural state
    state_e     state_q, state_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic [2:0] lives_q, lives_d;
    logic [3:0] level_q, level_d;
    logic       reload_q, reload_d;
    logic       hold_q, hold_d;
    logic       launch_q, launch_d;
    logic       play_q, play_d;
    logic       over_q, over_d;
`ifdef GAME_SEQ_SCORE_EN
    logic [SCORE_W-1:0] score_q, score_d;
`else
    logic               unused_block_hit_s;
    assign unused_block_hit_s = block_hit;
`endif

    // Bring the asynchronous select button into the clk domain and keep one delayed copy
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            sel_meta_q <= 1'b0;
            sel_sync_q <= 1'b0;
            sel_prev_q <= 1'b0;
        end else begin
            sel_meta_q <= btn_select;
            sel_sync_q <= sel_meta_q;
            sel_prev_q <= sel_sync_q;
        end
    end

    assign press_s = sel_sync_q & ~sel_prev_q;

    // Next-state, counter and registered-output computation for the game flow
    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        lives_d     = lives_q;
        level_d     = level_q;
        reload_d    = 1'b0;
        launch_d    = 1'b0;
`ifdef GAME_SEQ_SCORE_EN
        score_d     = score_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (press_s) begin
                    lives_d  = LIVES_INIT;
                    level_d  = 4'd0;
`ifdef GAME_SEQ_SCORE_EN
                    score_d  = '0;
`endif
                    reload_d = 1'b1;
                    state_d  = S_RELOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RELOAD: begin
                if (reload_done) begin
                    state_d = S_SERVE;
                end else begin
                    state_d = S_RELOAD;
                end
            end
            S_SERVE: begin
                if (press_s) begin
                    launch_d = 1'b1;
                    state_d  = S_PLAY;
                end else begin
                    state_d = S_SERVE;
                end
            end
            S_PLAY: begin
`ifdef GAME_SEQ_SCORE_EN
                // A hit is scored even when it coincides with a phase change
                if (block_hit && (score_q != {SCORE_W{1'b1}})) begin
                    score_d = score_q + SCORE_W'(1);
                end else begin
                    score_d = score_q;
                end
`endif
                // Clearing the level outranks losing the ball in the same cycle
                if (blocks_empty) begin
                    frame_cnt_d = 8'd0;
                    state_d     = S_CLEARED;
                end else if (ball_lost) begin
                    if (lives_q == 3'd1) begin
                        lives_d = 3'd0;
                        state_d = S_OVER;
                    end else begin
                        lives_d     = lives_q - 3'd1;
                        frame_cnt_d = 8'd0;
                        state_d     = S_LOST;
                    end
                end else begin
                    state_d = S_PLAY;
                end
            end
            S_LOST: begin
                if (frame_pulse) begin
                    if ((frame_cnt_q + 8'd1) == LOST_LIM) begin
                        frame_cnt_d = 8'd0;
                        state_d     = S_SERVE;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end
                end else begin
                    frame_cnt_d = frame_cnt_q;
                end
            end
            S_CLEARED: begin
                if (frame_pulse) begin
                    if ((frame_cnt_q + 8'd1) == CLEAR_LIM) begin
                        frame_cnt_d = 8'd0;
                        level_d     = level_q + 4'd1;
                        reload_d    = 1'b1;
                        state_d     = S_RELOAD;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end
                end else begin
                    frame_cnt_d = frame_cnt_q;
                end
            end
            S_OVER: begin
                if (press_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_OVER;
                end
            end
            default: begin
                // Unused encoding: fall back to the attract phase
                frame_cnt_d = 8'd0;
                state_d     = S_IDLE;
            end
        endcase

        // Level outputs follow the state being entered so they change with it
        hold_d = (state_d != S_PLAY);
        play_d = (state_d == S_PLAY);
        over_d = (state_d == S_OVER);
    end

    // Single state register holding the FSM, counters and all outputs
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q     <= S_IDLE;
            frame_cnt_q <= 8'd0;
            lives_q     <= LIVES_INIT;
            level_q     <= 4'd0;
            reload_q    <= 1'b0;
            hold_q      <= 1'b1;
            launch_q    <= 1'b0;
            play_q      <= 1'b0;
            over_q      <= 1'b0;
`ifdef GAME_SEQ_SCORE_EN
            score_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            lives_q     <= lives_d;
            level_q     <= level_d;
            reload_q    <= reload_d;
            hold_q      <= hold_d;
            launch_q    <= launch_d;
            play_q      <= play_d;
            over_q      <= over_d;
`ifdef GAME_SEQ_SCORE_EN
            score_q     <= score_d;
`endif
        end
    end

    assign blocks_reload = reload_q;
    assign ball_hold     = hold_q;
    assign ball_launch   = launch_q;
    assign play_active   = play_q;
    assign game_over     = over_q;
    assign lives         = lives_q;
    assign level         = level_q;
`ifdef GAME_SEQ_SCORE_EN
    assign score         = score_q;
`else
    assign score         = '0;
`endif

endmodule

// File: tb/tb_game_sequencer.sv
// -----------------------------------------------------------------------------
// tb_game_sequencer
//   Directed bench for game_sequencer. Drives a full game through reload,
//   serve, play, level clear, life loss, asynchronous reset and game over,
//   comparing outputs against hand-computed values.
// -----------------------------------------------------------------------------
module tb_game_sequencer;

    localparam int SW = 4;
`ifdef GAME_SEQ_SCORE_EN
    localparam int SCORE_ON = 1;
`else
    localparam int SCORE_ON = 0;
`endif

    logic          clk;
    logic          nRst;
    logic          frame_pulse;
    logic          btn_select;
    logic          ball_lost;
    logic          block_hit;
    logic          blocks_empty;
    logic          reload_done;
    logic          blocks_reload;
    logic          ball_hold;
    logic          ball_launch;
    logic          play_active;
    logic          game_over;
    logic [2:0]    lives;
    logic [3:0]    level;
    logic [SW-1:0] score;

    int tests_run    = 0;
    int tests_failed = 0;

    game_sequencer #(
        .START_LIVES (3),
        .LOST_FRAMES (90),
        .CLEAR_FRAMES(120),
        .SCORE_W     (SW)
    ) dut (
        .clk          (clk),
        .nRst         (nRst),
        .frame_pulse  (frame_pulse),
        .btn_select   (btn_select),
        .ball_lost    (ball_lost),
        .block_hit    (block_hit),
        .blocks_empty (blocks_empty),
        .reload_done  (reload_done),
        .blocks_reload(blocks_reload),
        .ball_hold    (ball_hold),
        .ball_launch  (ball_launch),
        .play_active  (play_active),
        .game_over    (game_over),
        .lives        (lives),
        .level        (level),
        .score        (score)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to just after the next active edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        for (int k = 0; k < n; k++) begin
            frame_pulse = 1'b1;
            tick();
            frame_pulse = 1'b0;
            tick();
        end
    endtask

    task automatic pulse_reload_done();
        reload_done = 1'b1;
        tick();
        reload_done = 1'b0;
        tick();
    endtask

    task automatic pulse_lost();
        ball_lost = 1'b1;
        tick();
        ball_lost = 1'b0;
    endtask

    // Press and release the button, noting any launch/reload pulse it causes
    task automatic do_press(output logic launch_seen, output logic reload_seen);
        launch_seen = 1'b0;
        reload_seen = 1'b0;
        btn_select  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (ball_launch)   launch_seen = 1'b1;
            if (blocks_reload) reload_seen = 1'b1;
        end
        btn_select = 1'b0;
        tick();
        if (ball_launch)   launch_seen = 1'b1;
        if (blocks_reload) reload_seen = 1'b1;
    endtask

    logic l_seen, r_seen;
    int   n_launch, launch_at;

    initial begin
        nRst = 1'b0; frame_pulse = 1'b0; btn_select = 1'b0; ball_lost = 1'b0;
        block_hit = 1'b0; blocks_empty = 1'b0; reload_done = 1'b0;
        tick(); tick();

        // Reset values
        check_eq("rst_hold",   32'(ball_hold),     32'd1);
        check_eq("rst_lives",  32'(lives),         32'd3);
        check_eq("rst_level",  32'(level),         32'd0);
        check_eq("rst_play",   32'(play_active),   32'd0);
        check_eq("rst_over",   32'(game_over),     32'd0);
        check_eq("rst_reload", 32'(blocks_reload), 32'd0);
        check_eq("rst_launch", 32'(ball_launch),   32'd0);
        check_eq("rst_score",  32'(score),         32'd0);
        nRst = 1'b1;
        tick();

        // 1: press in IDLE -> one reload pulse 3 clk after the edge, then SERVE
        btn_select = 1'b1;
        tick(); tick();
        check_eq("t1_reload_early", 32'(blocks_reload), 32'd0);
        tick();
        check_eq("t1_reload_pulse", 32'(blocks_reload), 32'd1);
        btn_select = 1'b0;
        tick();
        check_eq("t1_reload_end", 32'(blocks_reload), 32'd0);
        tick(); tick();
        pulse_reload_done();
        check_eq("t1_hold",  32'(ball_hold),   32'd1);
        check_eq("t1_lives", 32'(lives),       32'd3);
        check_eq("t1_level", 32'(level),       32'd0);
        check_eq("t1_play",  32'(play_active), 32'd0);

        // 2: hold the button for 50 clk in SERVE -> exactly one launch at clk 3
        n_launch  = 0;
        launch_at = 0;
        btn_select = 1'b1;
        for (int i = 1; i <= 50; i++) begin
            tick();
            if (ball_launch) begin
                n_launch++;
                launch_at = i;
            end
        end
        btn_select = 1'b0;
        tick();
        check_eq("t2_launch_count", 32'(n_launch),    32'd1);
        check_eq("t2_launch_at",    32'(launch_at),   32'd3);
        check_eq("t2_play",         32'(play_active), 32'd1);
        check_eq("t2_hold",         32'(ball_hold),   32'd0);

        // 5: 20 block hits saturate a 4-bit score (or stay 0 without the counter)
        for (int i = 1; i <= 20; i++) begin
            block_hit = 1'b1;
            tick();
            block_hit = 1'b0;
            tick();
            if (i == 3) check_eq("t5_score3", 32'(score), (SCORE_ON != 0) ? 32'd3 : 32'd0);
        end
        check_eq("t5_score_sat", 32'(score), (SCORE_ON != 0) ? 32'd15 : 32'd0);

        // 4: blocks_empty and ball_lost together -> CLEARED, lives kept
        blocks_empty = 1'b1;
        ball_lost    = 1'b1;
        tick();
        blocks_empty = 1'b0;
        ball_lost    = 1'b0;
        check_eq("t4_play",  32'(play_active), 32'd0);
        check_eq("t4_hold",  32'(ball_hold),   32'd1);
        check_eq("t4_lives", 32'(lives),       32'd3);
        check_eq("t4_over",  32'(game_over),   32'd0);
        frames(119);
        check_eq("t4_level_119",  32'(level),         32'd0);
        check_eq("t4_reload_119", 32'(blocks_reload), 32'd0);
        frame_pulse = 1'b1;
        tick();
        frame_pulse = 1'b0;
        check_eq("t4_level_120",  32'(level),         32'd1);
        check_eq("t4_reload_120", 32'(blocks_reload), 32'd1);
        tick();
        check_eq("t4_reload_end", 32'(blocks_reload), 32'd0);

        // In RELOAD a press is ignored
        do_press(l_seen, r_seen);
        check_eq("reload_press_ign", 32'(l_seen), 32'd0);
        pulse_reload_done();
        do_press(l_seen, r_seen);
        check_eq("serve_launch", 32'(l_seen),      32'd1);
        check_eq("serve_play",   32'(play_active), 32'd1);
        pulse_lost();
        check_eq("lost_lives", 32'(lives),     32'd2);
        check_eq("lost_hold",  32'(ball_hold), 32'd1);

        // 6: asynchronous reset during LOST at frame 40
        frames(40);
        #2;
        nRst = 1'b0;
        #1;
        check_eq("t6_lives",  32'(lives),       32'd3);
        check_eq("t6_level",  32'(level),       32'd0);
        check_eq("t6_hold",   32'(ball_hold),   32'd1);
        check_eq("t6_play",   32'(play_active), 32'd0);
        check_eq("t6_over",   32'(game_over),   32'd0);
        check_eq("t6_score",  32'(score),       32'd0);
        tick();
        nRst = 1'b1;
        tick();
        pulse_reload_done();
        do_press(l_seen, r_seen);
        check_eq("t6_idle_reload", 32'(r_seen), 32'd1);
        check_eq("t6_idle_launch", 32'(l_seen), 32'd0);

        // Lose two lives, checking the LOST wait length
        pulse_reload_done();
        do_press(l_seen, r_seen);
        check_eq("g_launch1", 32'(l_seen), 32'd1);
        pulse_lost();
        check_eq("g_lives2", 32'(lives), 32'd2);
        frames(89);
        do_press(l_seen, r_seen);
        check_eq("lost89_press_ign", 32'(l_seen), 32'd0);
        frames(1);
        do_press(l_seen, r_seen);
        check_eq("lost90_serve", 32'(l_seen), 32'd1);
        pulse_lost();
        check_eq("g_lives1", 32'(lives), 32'd1);
        frames(90);
        do_press(l_seen, r_seen);
        check_eq("g_launch3", 32'(l_seen), 32'd1);

        // 3: last life lost (with a coincident hit) -> OVER
        block_hit = 1'b1;
        ball_lost = 1'b1;
        tick();
        block_hit = 1'b0;
        ball_lost = 1'b0;
        check_eq("t3_lives", 32'(lives),       32'd0);
        check_eq("t3_over",  32'(game_over),   32'd1);
        check_eq("t3_play",  32'(play_active), 32'd0);
        check_eq("t3_score", 32'(score), (SCORE_ON != 0) ? 32'd1 : 32'd0);
        block_hit = 1'b1;
        ball_lost = 1'b1;
        tick();
        block_hit = 1'b0;
        ball_lost = 1'b0;
        tick();
        check_eq("t3_lives_frozen", 32'(lives),     32'd0);
        check_eq("t3_over_kept",    32'(game_over), 32'd1);
        check_eq("t3_score_frozen", 32'(score), (SCORE_ON != 0) ? 32'd1 : 32'd0);
        do_press(l_seen, r_seen);
        check_eq("t3_to_idle",   32'(game_over), 32'd0);
        check_eq("t3_no_reload", 32'(r_seen),    32'd0);
        check_eq("t3_hold",      32'(ball_hold), 32'd1);
        do_press(l_seen, r_seen);
        check_eq("restart_reload", 32'(r_seen), 32'd1);
        check_eq("restart_lives",  32'(lives),  32'd3);
        check_eq("restart_score",  32'(score),  32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
